dmr_wb_comparator: RTL and testbench

- Dual-modular-redundancy checker on the register-file write-back path of the fault-tolerant system.
- Compares the write requests (enable, address, data) of two lockstep core replicas A and B.
- Forwards an agreed write to the register file; flags any disagreement via `signal`.
- Keeps a sticky error flag and a saturating error counter for the recovery controller.

---
 rtl/dmr_wb_comparator.sv | 53 +++++
 tb/tb_dmr_wb_comparator.sv | 115 +++++++++++
 2 files changed

// File: rtl/dmr_wb_comparator.sv
// dmr_wb_comparator: compares lockstep replica write-backs, forwards agreed writes
// and tracks mismatches with a sticky flag and saturating counter.
module dmr_wb_comparator #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              we_a_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] data_a_i,
  input  logic [DATA_W-1:0] data_b_i,
  input  logic              clear_i,
  output logic              we_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [DATA_W-1:0] data_o,
  output logic              signal,
  output logic              err_sticky_o,
  output logic [CNT_W-1:0]  err_cnt_o
);
  logic mismatch, agree;
  // addresses and data only matter when both replicas actually write
  assign mismatch = (we_a_i != we_b_i) |
                    (we_a_i & we_b_i & ((addr_a_i != addr_b_i) | (data_a_i != data_b_i)));
  assign agree = we_a_i & we_b_i & ~mismatch;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      we_o         <= 1'b0;
      addr_o       <= '0;
      data_o       <= '0;
      signal       <= 1'b0;
      err_sticky_o <= 1'b0;
      err_cnt_o    <= '0;
    end else begin
      signal <= mismatch;
      we_o   <= agree;
      if (agree) begin
        addr_o <= addr_a_i;
        data_o <= data_a_i;
      end
      if (clear_i) begin
        err_sticky_o <= 1'b0;
        err_cnt_o    <= '0;
      end else if (mismatch) begin
        err_sticky_o <= 1'b1;
        err_cnt_o    <= (&err_cnt_o) ? err_cnt_o : err_cnt_o + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_dmr_wb_comparator.sv
// tb_dmr_wb_comparator: directed plus randomized checks against a behavioural model.
module tb_dmr_wb_comparator;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        we_a = 1'b0, we_b = 1'b0, clr = 1'b0;
  logic [4:0]  addr_a = '0, addr_b = '0;
  logic [31:0] data_a = '0, data_b = '0;
  logic        we_o, signal, sticky;
  logic [4:0]  addr_o;
  logic [31:0] data_o;
  logic [7:0]  cnt;

  int checks = 0, errors = 0;
  logic        m_we = 0, m_sig = 0, m_sticky = 0;
  logic [4:0]  m_addr = 0;
  logic [31:0] m_data = 0;
  int          m_cnt = 0;

  dmr_wb_comparator dut (
    .clk_i(clk), .rst_ni(rst_n),
    .we_a_i(we_a), .we_b_i(we_b),
    .addr_a_i(addr_a), .addr_b_i(addr_b),
    .data_a_i(data_a), .data_b_i(data_b),
    .clear_i(clr),
    .we_o(we_o), .addr_o(addr_o), .data_o(data_o),
    .signal(signal), .err_sticky_o(sticky), .err_cnt_o(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".we_o"}, 32'(we_o), 32'(m_we));
    chk({tag, ".addr_o"}, 32'(addr_o), 32'(m_addr));
    chk({tag, ".data_o"}, data_o, m_data);
    chk({tag, ".signal"}, 32'(signal), 32'(m_sig));
    chk({tag, ".sticky"}, 32'(sticky), 32'(m_sticky));
    chk({tag, ".cnt"}, 32'(cnt), 32'(m_cnt));
  endtask

  task automatic model_reset();
    m_we = 0; m_addr = 0; m_data = 0; m_sig = 0; m_sticky = 0; m_cnt = 0;
  endtask

  // one request per cycle; the model decides agreement from the two requests as a whole
  task automatic step(input string tag, input logic wa, input logic wb,
                      input logic [4:0] aa, input logic [4:0] ab,
                      input logic [31:0] da, input logic [31:0] db, input logic c);
    logic same;
    @(negedge clk);
    we_a = wa; we_b = wb; addr_a = aa; addr_b = ab; data_a = da; data_b = db; clr = c;
    same = (wa == wb) && (!wa || (aa == ab && da == db));
    @(posedge clk);
    #1;
    m_sig = !same;
    m_we = wa && same;
    if (wa && same) begin m_addr = aa; m_data = da; end
    if (c) begin m_sticky = 0; m_cnt = 0; end
    else if (!same) begin m_sticky = 1; m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1; end
    chk_all(tag);
  endtask

  initial begin
    #1;
    chk_all("reset_async");
    @(posedge clk); #1;
    chk_all("reset_held");
    @(negedge clk); rst_n = 1'b1;
    step("agree_10", 1, 1, 10, 10, 100, 100, 0);
    step("we_diff", 1, 0, 10, 10, 100, 100, 0);
    step("addr_diff", 1, 1, 10, 11, 100, 100, 0);
    step("data_diff", 1, 1, 10, 10, 120, 100, 0);
    step("agree_120", 1, 1, 10, 10, 120, 120, 0);
    step("clear", 0, 0, 0, 0, 0, 0, 1);
    step("idle_ignored", 0, 0, 3, 7, 1, 2, 0);
    step("clear_vs_mm", 0, 1, 3, 3, 5, 5, 1);
    for (int i = 0; i < 300; i++)
      step("saturate", 1, 1, 5'(i), 5'(i + 1), 32'(i), 32'(i), 0);
    chk("sat_final", 32'(cnt), 32'd255);
    step("sat_agree", 1, 1, 4, 4, 77, 77, 0);
    step("sat_hold", 1, 0, 4, 4, 77, 77, 0);
    for (int i = 0; i < 200; i++) begin
      logic        wa, wb, c;
      logic [4:0]  aa, ab;
      logic [31:0] da, db;
      wa = 1'($urandom);
      wb = ($urandom_range(0, 7) == 0) ? !wa : wa;
      aa = 5'($urandom);
      ab = ($urandom_range(0, 5) == 0) ? 5'($urandom) : aa;
      da = $urandom;
      db = ($urandom_range(0, 5) == 0) ? da ^ (32'd1 << $urandom_range(0, 31)) : da;
      c  = ($urandom_range(0, 15) == 0);
      step("random", wa, wb, aa, ab, da, db, c);
    end
    step("pre_rst", 1, 1, 9, 9, 32'hdead, 32'hdead, 0);
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_all("mid_rst");
    @(posedge clk); #1;
    chk_all("mid_rst_held");
    @(negedge clk); rst_n = 1'b1;
    step("post_rst", 1, 1, 21, 21, 32'hbeef, 32'hbeef, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
